// File: rtl/shift_unit_seq_if.sv
// Valid/ready command and result bus for shift_unit_seq.
// master drives commands and accepts results; slave is the shift unit.
interface shift_unit_seq_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   amt;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
  logic             busy;

  modport master (
    output in_valid, data_in, amt, mode, out_ready,
    input  in_ready, out_valid, data_out, carry_out, busy
  );

  modport slave (
    input  in_valid, data_in, amt, mode, out_ready,
    output in_ready, out_valid, data_out, carry_out, busy
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit (LSL/LSR/ASL/ASR/ROL/ROR) with carry out.
// Define SHIFT_FAST_EN for a single-cycle barrel path instead of one bit per clock.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  shift_unit_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_p1;
  logic             carry_p1;
  logic             accept;
  logic             reserved_in;

  assign accept      = bus.in_valid && (state_q == IDLE);
  assign reserved_in = (bus.mode[2:1] == 2'b11);

`ifdef SHIFT_FAST_EN
  // Full shift by a; returns {carry, result}. a==0 yields {0, v}.
  function automatic logic [WIDTH:0] barrel(input logic [2:0] m,
                                            input logic [WIDTH-1:0] v,
                                            input logic [SHW-1:0] a);
    logic [WIDTH:0]          wl;
    logic [WIDTH:0]          wr;
    logic signed [WIDTH:0]   ws;
    logic [2*WIDTH-1:0]      dbl;
    logic [WIDTH-1:0]        r;
    barrel = {1'b0, v};
    case (m)
      3'd0, 3'd2: begin
        wl     = {1'b0, v} << a;
        barrel = wl;
      end
      3'd1: begin
        wr     = {v, 1'b0} >> a;
        barrel = {wr[0], wr[WIDTH:1]};
      end
      3'd3: begin
        ws     = $signed({v, 1'b0}) >>> a;
        barrel = {ws[0], ws[WIDTH:1]};
      end
      3'd4: begin
        dbl    = {v, v} << a;
        r      = dbl[2*WIDTH-1:WIDTH];
        barrel = {(|a) & r[0], r};
      end
      3'd5: begin
        dbl    = {v, v} >> a;
        r      = dbl[WIDTH-1:0];
        barrel = {(|a) & r[WIDTH-1], r};
      end
      default: barrel = {1'b0, v};
    endcase
  endfunction
`else
  logic [SHW-1:0] cnt_p1;
  logic [2:0]     mode_p1;

  // One-position step; returns {carry, result}.
  function automatic logic [WIDTH:0] step1(input logic [2:0] m,
                                           input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (m)
      3'd0, 3'd2: step1 = {v, 1'b0};
      3'd1:       step1 = {v[0], 1'b0, v[WIDTH-1:1]};
      3'd3:       step1 = {v[0], sv >>> 1};
      3'd4:       step1 = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      3'd5:       step1 = {v[0], v[0], v[WIDTH-1:1]};
      default:    step1 = {1'b0, v};
    endcase
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SHIFT_FAST_EN
          state_d = DONE;
`else
          state_d = (bus.amt == '0 || reserved_in) ? DONE : SHIFT;
`endif
        end
      end
`ifndef SHIFT_FAST_EN
      SHIFT:   if (cnt_p1 == SHW'(1)) state_d = DONE;
`endif
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
  end

  assign bus.data_out  = res_p1;
  assign bus.carry_out = carry_p1;

  // Working register: the result must read zero out of reset, so it is cleared too
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1   <= '0;
      carry_p1 <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef SHIFT_FAST_EN
            if (reserved_in) {carry_p1, res_p1} <= {1'b0, bus.data_in};
            else             {carry_p1, res_p1} <= barrel(bus.mode, bus.data_in, bus.amt);
`else
            res_p1   <= bus.data_in;
            carry_p1 <= 1'b0;
            cnt_p1   <= bus.amt;
            mode_p1  <= bus.mode;
`endif
          end
        end
`ifndef SHIFT_FAST_EN
        SHIFT: begin
          {carry_p1, res_p1} <= step1(mode_p1, res_p1);
          cnt_p1             <= cnt_p1 - SHW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: directed vectors push expectations,
// a negedge monitor pops and compares each accepted result.
module tb_shift_unit_seq;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   first_seen = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_seq_if #(.WIDTH(WIDTH)) bus ();
  shift_unit_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       c;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency counted in edges from acceptance up to first visible out_valid
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      first_seen = -1;
    end else if (bus.out_valid) begin
      if (first_seen < 0) first_seen = cyc;
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data 0x%0h, expected no result", bus.data_out);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".data"}, 32'(bus.data_out), 32'(e.d));
          chk({e.name, ".carry"}, 32'(bus.carry_out), 32'(e.c));
          chk({e.name, ".latency"}, 32'(first_seen - e.acc + 1), 32'(e.lat));
        end
        first_seen = -1;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 64 cycles");
    end
  endtask

  task automatic issue(input string name, input logic [7:0] d, input logic [2:0] amt,
                       input logic [2:0] mode, input logic [7:0] ed, input logic ec,
                       input bit push);
    exp_t e;
    wait_ready();
    bus.data_in  = d;
    bus.amt      = amt;
    bus.mode     = mode;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.name = name;
    e.d    = ed;
    e.c    = ec;
`ifdef SHIFT_FAST_EN
    e.lat  = 1;
`else
    e.lat  = (amt == 3'd0 || mode[2:1] == 2'b11) ? 1 : int'(amt) + 1;
`endif
    e.acc  = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.amt       = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.data_out", 32'(bus.data_out), 32'd0);
    chk("reset.carry_out", 32'(bus.carry_out), 32'd0);
    rst = 1'b0;

    issue("lsl_b1_3",  8'hB1, 3'd3, 3'd0, 8'h88, 1'b1, 1'b1);
    issue("asr_96_2",  8'h96, 3'd2, 3'd3, 8'hE5, 1'b1, 1'b1);
    issue("ror_01_1",  8'h01, 3'd1, 3'd5, 8'h80, 1'b1, 1'b1);
    issue("rol_81_4",  8'h81, 3'd4, 3'd4, 8'h18, 1'b0, 1'b1);
    issue("lsr_5a_0",  8'h5A, 3'd0, 3'd1, 8'h5A, 1'b0, 1'b1);
    issue("rsv7_3c_5", 8'h3C, 3'd5, 3'd7, 8'h3C, 1'b0, 1'b1);
    issue("rsv6_ff_0", 8'hFF, 3'd0, 3'd6, 8'hFF, 1'b0, 1'b1);
    issue("lsr_f8_4",  8'hF8, 3'd4, 3'd1, 8'h0F, 1'b1, 1'b1);
    issue("asl_7f_7",  8'h7F, 3'd7, 3'd2, 8'h80, 1'b1, 1'b1);
    issue("asr_7f_7",  8'h7F, 3'd7, 3'd3, 8'h00, 1'b1, 1'b1);
    issue("ror_a5_7",  8'hA5, 3'd7, 3'd5, 8'h4B, 1'b0, 1'b1);

    // Backpressure: result held three cycles, a stray command is ignored
    wait_ready();
    bus.out_ready = 1'b0;
    issue("bp_lsl_b1", 8'hB1, 3'd3, 3'd0, 8'h88, 1'b1, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk("bp.out_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.hold%0d.data", i), 32'(bus.data_out), 32'h88);
      chk($sformatf("bp.hold%0d.carry", i), 32'(bus.carry_out), 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      if (i == 1) begin
        bus.data_in  = 8'hFF;
        bus.amt      = 3'd1;
        bus.mode     = 3'd0;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp.after.in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp.after.out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.after.busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a long command
    bus.out_ready = 1'b0;
    issue("rst_lsl_ff_7", 8'hFF, 3'd7, 3'd0, 8'h80, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.data_out", 32'(bus.data_out), 32'd0);
    chk("rst.carry_out", 32'(bus.carry_out), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    issue("post_rst_asr_96_2", 8'h96, 3'd2, 3'd3, 8'hE5, 1'b1, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
